// File: rtl/csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : csa_accumulator
// Purpose  : Multi-lane carry-save accumulator. Each accepted beat is folded
//            into a redundant sum/carry state via 3:2 compressors. One
//            carry-propagate add resolves the packet total after its last beat.
// Options  : define CSA_ACC_COUNT_EN to add a saturating beat counter that
//            drives out_count_o.
// Revision : 1.0  initial release
// ============================================================================
module csa_accumulator #(
    parameter int IN_W   = 24,
    parameter int ACC_W  = 49,
    parameter int LANES  = 2,
    parameter int SIGNED = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [LANES*IN_W-1:0]   in_data_i,
    input  logic                    in_last_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [ACC_W-1:0]        out_sum_o
`ifdef CSA_ACC_COUNT_EN
    ,
    output logic [CNT_W-1:0]        out_count_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCUM   = 2'd1,
        S_RESOLVE = 2'd2,
        S_OUT     = 2'd3
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_sum_s;
    logic [ACC_W-1:0]   r_sum_c;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_valid;
    logic               w_accept;

    // Compressor chain: stage k folds lane k into the running (sum, carry) pair.
    logic [ACC_W-1:0]   w_ext   [LANES];
    logic [ACC_W-1:0]   w_s     [LANES+1];
    logic [ACC_W-1:0]   w_c     [LANES+1];

    if (LANES < 1 || LANES > 4 || ACC_W < IN_W || ACC_W < 2 || CNT_W < 1) begin : g_param_check
        $error("csa_accumulator: illegal parameter combination");
    end

    assign in_ready_o  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept    = in_valid_i && in_ready_o;
    assign out_valid_o = r_out_valid;
    assign out_sum_o   = r_out_sum;

    assign w_s[0] = r_sum_s;
    assign w_c[0] = r_sum_c;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IN_W-1:0]  w_lane;
        logic [ACC_W-1:0] w_maj;

        assign w_lane = in_data_i[k*IN_W +: IN_W];

        if (ACC_W > IN_W && SIGNED != 0) begin : g_sext
            assign w_ext[k] = {{(ACC_W-IN_W){w_lane[IN_W-1]}}, w_lane};
        end else if (ACC_W > IN_W) begin : g_zext
            assign w_ext[k] = {{(ACC_W-IN_W){1'b0}}, w_lane};
        end else begin : g_noext
            assign w_ext[k] = w_lane;
        end

        assign w_maj      = (w_s[k] & w_c[k]) | (w_s[k] & w_ext[k]) | (w_c[k] & w_ext[k]);
        assign w_s[k+1]   = w_s[k] ^ w_c[k] ^ w_ext[k];
        // Shift drops the carry out of bit ACC_W-1, giving modulo-2^ACC_W wrap.
        assign w_c[k+1]   = w_maj << 1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_sum_s     <= '0;
            r_sum_c     <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (in_valid_i) begin
                        r_sum_s <= w_s[LANES];
                        r_sum_c <= w_c[LANES];
                        r_state <= in_last_i ? S_RESOLVE : S_ACCUM;
                    end
                end
                S_RESOLVE: begin
                    r_out_sum   <= r_sum_s + r_sum_c;
                    r_sum_s     <= '0;
                    r_sum_c     <= '0;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CSA_ACC_COUNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_out_count;

    assign out_count_o = r_out_count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_out_count <= '0;
        end else if (r_state == S_RESOLVE) begin
            r_out_count <= r_cnt;
            r_cnt       <= '0;
        end else if (w_accept && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    logic w_unused_accept;
    assign w_unused_accept = w_accept;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csa_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_accumulator
// Purpose  : Directed and randomized bench for csa_accumulator; packet totals
//            are compared against a plain-arithmetic reference sum.
// Revision : 1.0  initial release
// ============================================================================
module tb_csa_accumulator;

    localparam int IN_W  = 24;
    localparam int ACC_W = 49;
    localparam int LANES = 2;
    localparam int CNT_W = 16;
    localparam int N_PKT = 1000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready, in_last, out_valid, out_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [ACC_W-1:0]       out_sum;

    logic                   in_valid8, in_ready8, in_last8, out_valid8, out_ready8;
    logic [31:0]            in_data8;
    logic [7:0]             out_sum8;
`ifdef CSA_ACC_COUNT_EN
    logic [CNT_W-1:0]       out_count;
    logic [1:0]             out_count8;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    csa_accumulator #(
        .IN_W(IN_W), .ACC_W(ACC_W), .LANES(LANES), .SIGNED(1), .CNT_W(CNT_W)
    ) u_dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sum_o(out_sum)
`ifdef CSA_ACC_COUNT_EN
        , .out_count_o(out_count)
`endif
    );

    csa_accumulator #(
        .IN_W(8), .ACC_W(8), .LANES(4), .SIGNED(0), .CNT_W(2)
    ) u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid8), .in_ready_o(in_ready8),
        .in_data_i(in_data8), .in_last_i(in_last8),
        .out_valid_o(out_valid8), .out_ready_i(out_ready8),
        .out_sum_o(out_sum8)
`ifdef CSA_ACC_COUNT_EN
        , .out_count_o(out_count8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [IN_W-1:0] l0, input logic [IN_W-1:0] l1, input logic last);
        in_valid = 1'b1;
        in_data  = {l1, l0};
        in_last  = last;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic longint sx(input logic [IN_W-1:0] v);
        return longint'($signed(v));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ACC_W-1:0] exp_q[$];
        int               cnt_q[$];
        longint           acc;
        int               pkts_sent, pkts_done, pkt_len, beat_idx, cycles;
        bit               have_beat;
        logic [ACC_W-1:0] exp_sum;
        int               exp_cnt;

        rst = 1'b1;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 0;
        in_valid8 = 0; in_data8 = '0; in_last8 = 0; out_ready8 = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        check("reset_ready", in_ready, 1);
        check("reset_valid", out_valid, 0);
        check("reset_sum", out_sum, 0);

        // single-beat packet and its latency
        drive(24'd5, 24'd7, 1'b1);
        tick();
        in_valid = 1'b0;
        check("t1_resolve_ready", in_ready, 0);
        check("t1_early_valid", out_valid, 0);
        tick();
        check("t1_valid", out_valid, 1);
        check("t1_sum", out_sum, 12);
`ifdef CSA_ACC_COUNT_EN
        check("t1_count", out_count, 1);
`endif
        handshake();
        check("t1_valid_drop", out_valid, 0);
        check("t1_ready_back", in_ready, 1);

        // three beats of {-1,-1}
        for (int i = 0; i < 3; i++) begin
            drive(24'hFF_FFFF, 24'hFF_FFFF, i == 2);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t2_valid", out_valid, 1);
        check("t2_sum", out_sum, 49'h1_FFFF_FFFF_FFFA);
`ifdef CSA_ACC_COUNT_EN
        check("t2_count", out_count, 3);
`endif

        // backpressure: beat held while result is pending
        drive(24'd1, 24'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold_sum", out_sum, 49'h1_FFFF_FFFF_FFFA);
            check("t3_hold_ready", in_ready, 0);
        end
        handshake();
        check("t3_released", out_valid, 0);
        check("t3_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t3_no_early", out_valid, 0);
        tick();
        check("t3_valid", out_valid, 1);
        check("t3_sum", out_sum, 2);
        handshake();

        // reset mid-packet discards partial state
        drive(24'd3, 24'd4, 1'b0);
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        tick();
        drive(24'd1, 24'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_sum", out_sum, 3);
        handshake();

        // unsigned 8-bit, four lanes: wrap modulo 2^8
        in_valid8 = 1'b1; in_data8 = 32'hFFFF_FFFF; in_last8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick();
        check("t4_valid", out_valid8, 1);
        check("t4_sum", out_sum8, 8'hFC);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
`ifdef CSA_ACC_COUNT_EN
        // 2-bit counter saturates at 3 on a 6-beat packet
        for (int i = 0; i < 6; i++) begin
            in_valid8 = 1'b1; in_data8 = 32'h0101_0101; in_last8 = (i == 5);
            tick();
        end
        in_valid8 = 1'b0;
        tick();
        check("t6_sum", out_sum8, 8'h18);
        check("t6_count_sat", out_count8, 3);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
`endif

        // randomized packets against a running-sum reference
        acc = 0; pkts_sent = 0; pkts_done = 0; pkt_len = 0; beat_idx = 0;
        cycles = 0; have_beat = 0;
        while (pkts_done < N_PKT && cycles < 80000) begin
            if (!have_beat && pkts_sent < N_PKT && $urandom_range(0, 3) != 0) begin
                if (beat_idx == 0) pkt_len = $urandom_range(1, 20);
                in_data   = {24'($urandom), 24'($urandom)};
                in_last   = (beat_idx + 1 == pkt_len);
                in_valid  = 1'b1;
                have_beat = 1;
            end else if (!have_beat) begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid) check("rand_ready_excl", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_spurious_out", 1, 0);
                end else begin
                    exp_sum = exp_q.pop_front();
                    exp_cnt = cnt_q.pop_front();
                    check("rand_sum", out_sum, exp_sum);
`ifdef CSA_ACC_COUNT_EN
                    check("rand_count", out_count, exp_cnt);
`endif
                end
                pkts_done++;
            end
            if (in_valid && in_ready) begin
                acc += sx(in_data[IN_W-1:0]) + sx(in_data[2*IN_W-1:IN_W]);
                beat_idx++;
                have_beat = 0;
                if (in_last) begin
                    exp_q.push_back(acc[ACC_W-1:0]);
                    cnt_q.push_back(beat_idx);
                    acc = 0;
                    beat_idx = 0;
                    pkts_sent++;
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        if (pkts_done < N_PKT) check("rand_timeout", pkts_done, N_PKT);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
